radix4_approx: RTL and testbench



---
 rtl/radix4_approx.sv | 96 +++++++++
 tb/tb_radix4_approx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/radix4_approx.sv
// Approximate 32x32 unsigned radix-4 Booth multiplier with one register stage.
// Low APPROX_COLS columns treat digits +-2 as +-1; define RADIX4_APPROX_EXACT_EN for an exact product.
module radix4_approx #(
    parameter int unsigned APPROX_COLS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    output logic [63:0] P
);

    localparam int unsigned W    = 32;
    localparam int unsigned PW   = 64;
    localparam int unsigned ROWS = 17;
    localparam int unsigned RW   = 34;

`ifdef RADIX4_APPROX_EXACT_EN
    localparam bit EXACT_ONLY = 1'b1;
`else
    localparam bit EXACT_ONLY = 1'b0;
`endif

    // Operands padded so index k+1 holds bit k and index 0 holds bit -1.
    logic [W+2:0]    w_ax;
    logic [W+2:0]    w_bx;
    logic [ROWS-1:0] w_neg;
    logic [ROWS-1:0] w_one;
    logic [ROWS-1:0] w_two;
    logic [ROWS-1:0] w_nz;
    logic [RW-1:0]   w_row [ROWS];
    logic [PW-1:0]   w_prod;
    logic [PW-1:0]   r_p;
    logic            r_valid;

    assign w_ax = {2'b00, A, 1'b0};
    assign w_bx = {2'b00, B, 1'b0};

    // Booth digit recoding of B.
    always_comb begin
        w_neg = '0;
        w_one = '0;
        w_two = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            w_neg[i] = w_bx[2*i+2];
            w_one[i] = w_bx[2*i+1] ^ w_bx[2*i];
            w_two[i] = (w_bx[2*i+2] & ~w_bx[2*i+1] & ~w_bx[2*i])
                     | (~w_bx[2*i+2] & w_bx[2*i+1] & w_bx[2*i]);
        end
    end

    assign w_nz = w_one | w_two;

    // Partial-product bits; column 2i+j below APPROX_COLS uses the +-2 -> +-1 form.
    always_comb begin
        for (int unsigned i = 0; i < ROWS; i++) begin
            w_row[i] = '0;
            for (int unsigned j = 0; j < RW; j++) begin
                if (!EXACT_ONLY && ((2*i + j) < APPROX_COLS)) begin
                    w_row[i][j] = w_nz[i] & (w_ax[j+1] ^ w_neg[i]);
                end else begin
                    w_row[i][j] = (w_one[i] & (w_ax[j+1] ^ w_neg[i]))
                                | (w_two[i] & (w_ax[j]   ^ w_neg[i]));
                end
            end
        end
    end

    // A 111 group is a zero digit: gating its +1 keeps that row at zero.
    always_comb begin
        w_prod = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            w_prod = w_prod
                   + (PW'({{(PW-RW){w_row[i][RW-1]}}, w_row[i]}) << (2*i))
                   + (PW'(w_neg[i] & w_nz[i]) << (2*i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p     <= '0;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_p     <= w_prod;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign P         = r_p;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_radix4_approx.sv
// Scoreboard bench for radix4_approx: an APPROX_COLS=16 and an APPROX_COLS=0 instance share stimulus.
module tb_radix4_approx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic [63:0] p;
    logic        out_valid0;
    logic [63:0] p0;

    typedef struct {
        logic [63:0] p16;
        logic [63:0] p0;
    } exp_t;

    exp_t        sb_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] last16 = '0;
    logic [63:0] last0 = '0;
    logic        ev = 1'b0;

`ifdef RADIX4_APPROX_EXACT_EN
    localparam logic [63:0] ONE_TWO_16 = 64'd2;
`else
    localparam logic [63:0] ONE_TWO_16 = 64'd3;
`endif

    always #5 clk = ~clk;

    radix4_approx u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
        .out_valid(out_valid), .P(p)
    );

    radix4_approx #(.APPROX_COLS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
        .out_valid(out_valid0), .P(p0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit-level golden model: each row is +-(magnitude) with +-2 read as +-1 in masked columns.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input int cols);
`ifdef RADIX4_APPROX_EXACT_EN
        return 64'(x) * 64'(y) + 64'(cols - cols);
`else
        logic [63:0] acc;
        logic [34:0] yx;
        logic [33:0] xa, xe, m, mag;
        int d;
        acc = '0;
        yx  = {2'b00, y, 1'b0};
        for (int i = 0; i < 17; i++) begin
            d   = int'(yx[2*i+1]) + int'(yx[2*i]) - 2 * int'(yx[2*i+2]);
            xa  = (d == 0) ? 34'd0 : {2'b00, x};
            xe  = (d == 2 || d == -2) ? {1'b0, x, 1'b0} : xa;
            m   = '0;
            for (int j = 0; j < 34; j++) if (2*i + j < cols) m[j] = 1'b1;
            mag = (xe & ~m) | (xa & m);
            if (d < 0) acc = acc - (64'(mag) << (2*i));
            else       acc = acc + (64'(mag) << (2*i));
        end
        return acc;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ev <= 1'b0;
        else        ev <= in_valid;
    end

    // Monitor: compare valid flags every cycle, pop on a result, otherwise expect P held.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("out_valid",  64'(out_valid),  64'(ev));
            check("out_valid0", 64'(out_valid0), 64'(ev));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_depth", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("P16", p, e.p16);
                    check("P0", p0, e.p0);
                    last16 = e.p16;
                    last0  = e.p0;
                end
            end else begin
                check("hold16", p, last16);
                check("hold0", p0, last0);
            end
        end
    end

    task automatic drive(input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e16, input logic [63:0] e0);
        exp_t e;
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1'b1;
        e.p16 = e16;
        e.p0  = e0;
        sb_q.push_back(e);
    endtask

    task automatic drive_rand(input logic [31:0] x, input logic [31:0] y);
        drive(x, y, model(x, y, 16), model(x, y, 0));
    endtask

    task automatic drive_exact(input logic [31:0] x, input logic [31:0] y);
        drive(x, y, 64'(x) * 64'(y), 64'(x) * 64'(y));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] x, y;
        void'($urandom(7));

        // Reset held with live stimulus.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            in_valid = ~in_valid;
            check("rst_P", p, 64'd0);
            check("rst_P0", p0, 64'd0);
            check("rst_valid", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        drive(32'd3, 32'd5, 64'd15, 64'd15);
        idle(2);

        drive_exact(32'hFFFF_FFFF, 32'd1);
        drive_exact(32'h1234_5678, 32'h5555_5555);
        drive_exact(32'h0, 32'hFFFF_FFFF);
        drive_exact(32'hDEAD_BEEF, 32'h0);
        idle(2);

        drive(32'd1, 32'd2, ONE_TWO_16, 64'd2);
        idle(1);

        drive_rand(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive_rand(32'hFFFF_FFFF, 32'hAAAA_AAAA);
        drive_rand(32'h8000_0000, 32'h8000_0000);
        drive_rand(32'h0000_FFFF, 32'h0000_0002);
        drive_rand(32'h1357_9BDF, 32'h6666_6666);
        idle(3);

        // Back-to-back stream, then in_valid drops.
        for (int k = 0; k < 20; k++) drive_rand($urandom, $urandom);
        idle(4);

        // Reset mid-stream discards the pending result asynchronously.
        drive_rand(32'h0000_1234, 32'h0000_5678);
        drive_rand(32'h0BAD_F00D, 32'h0000_7777);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_P", p, 64'd0);
        check("async_rst_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        last16 = '0;
        last0  = '0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);

        for (int k = 0; k < 500; k++) begin
            x = $urandom % 32'hFFFF_FFFF;
            y = $urandom % 32'hFFFF_FFFF;
            drive_rand(x, y);
            idle(4);
        end

        idle(3);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
